// File: rtl/dmem_responder.sv
// Single-port data memory responder for a CPU: one outstanding request, response after LATENCY cycles,
// held until resp_ready. Optional MMIO cycle counter / LED register under DMEM_RESPONDER_MMIO_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mmio_led
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] CNT_ADDR = 32'hFFFF_FF00;
  localparam logic [31:0] LED_ADDR = 32'hFFFF_FF04;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_we_q, req_we_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] rd_word_q, rd_word_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          acc_err;
  logic          mem_we;
  logic [AW-1:0] acc_idx;
  logic          resp_err_int;

  function automatic logic in_ram(input logic [31:0] a);
    return a[31:AW+2] == '0;
  endfunction

  function automatic logic addr_err(input logic [31:0] a, input logic we);
    if (a[1:0] != 2'b00) return 1'b1;
`ifdef DMEM_RESPONDER_MMIO_EN
    if (a == CNT_ADDR) return we;
    if (a == LED_ADDR) return 1'b0;
`else
    if (we && 1'b0) return 1'b1;
`endif
    return !in_ram(a);
  endfunction

  assign req_ready = (state_q == IDLE);
  assign accept    = (state_q == IDLE) && req_valid && !rst;
  assign acc_idx   = req_addr[AW+1:2];
  assign acc_err   = addr_err(req_addr, req_we);
  assign mem_we    = accept && req_we && !acc_err && in_ram(req_addr);

  // Writes commit at the acceptance edge; the response phase only reports.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) mem[acc_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

`ifdef DMEM_RESPONDER_MMIO_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] led_q, led_d;

  always_comb begin
    cyc_d = cyc_q + 32'd1;
    led_d = led_q;
    if (accept && req_we && req_addr == LED_ADDR) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) led_d[8*b +: 8] = req_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      led_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      led_q <= led_d;
    end
  end

  assign mmio_led = led_q;
`else
  assign mmio_led = '0;
`endif

  // Read data is snapshotted at acceptance so the counter value reflects that edge.
  always_comb begin
    rd_word_d  = rd_word_q;
    req_we_d   = req_we_q;
    req_addr_d = req_addr_q;
    if (accept) begin
      req_we_d   = req_we;
      req_addr_d = req_addr;
      rd_word_d  = '0;
      if (in_ram(req_addr)) begin
        rd_word_d = mem[acc_idx];
      end
`ifdef DMEM_RESPONDER_MMIO_EN
      else if (req_addr == CNT_ADDR) begin
        rd_word_d = cyc_q;
      end else if (req_addr == LED_ADDR) begin
        rd_word_d = led_q;
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_we_q   <= 1'b0;
      req_addr_q <= '0;
      rd_word_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_we_q   <= req_we_d;
      req_addr_q <= req_addr_d;
      rd_word_q  <= rd_word_d;
    end
  end

  assign resp_valid   = (state_q == RESP);
  assign resp_err_int = addr_err(req_addr_q, req_we_q);
  assign resp_err     = resp_valid && resp_err_int;
  assign resp_rdata   = (resp_valid && !req_we_q && !resp_err_int) ? rd_word_q : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at default parameters; MMIO checks follow DMEM_RESPONDER_MMIO_EN.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mmio_led;

  int checks = 0;
  int errors = 0;

  dmem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mmio_led   (mmio_led)
  );

  always #5 clk = ~clk;

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  // lat counts negedge samples after the acceptance edge up to the first resp_valid (20 = timeout).
  task automatic drive_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                           output int lat);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_wstrb  = strb;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== 34'd0) begin
      errors++; $display("FAIL reset_resp: got valid=%b err=%b rdata=%h expected all 0", resp_valid, resp_err, resp_rdata);
    end
    checks++;
    if (mmio_led !== 32'd0) begin errors++; $display("FAIL reset_led: got %h expected 0", mmio_led); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat;
    drive_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", lat); end
    checks++;
    if ({er, rd} !== 33'd0) begin errors++; $display("FAIL wr_resp: got err=%b rdata=%h expected 0/0", er, rd); end
    drive_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++; $display("FAIL rd_data: got err=%b rdata=%h expected 0/deadbeef", er, rd);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int lat;
    drive_txn(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    drive_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, rd, er, lat);
    drive_txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h11BB33DD || er !== 1'b0) begin
      errors++; $display("FAIL byte_lanes: got err=%b rdata=%h expected 0/11bb33dd", er, rd);
    end
    drive_txn(1'b1, 32'h20, 32'h55667788, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL strb0_err: got %b expected 0", er); end
    drive_txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strb0_noop: got %h expected 11bb33dd", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    drive_txn(1'b1, 32'h0, 32'h12345678, 4'hF, rd, er, lat);
    drive_txn(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, rd, er, lat);
    drive_txn(1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      errors++; $display("FAIL misaligned: got err=%b rdata=%h expected 1/0", er, rd);
    end
    drive_txn(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL unmapped_wr: got err=%b expected 1", er); end
    drive_txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h12345678 || er !== 1'b0) begin
      errors++; $display("FAIL word0_intact: got err=%b rdata=%h expected 0/12345678", er, rd);
    end
    drive_txn(1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      errors++; $display("FAIL last_word: got err=%b rdata=%h expected 0/cafef00d", er, rd);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0 || resp_err !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL hold_stable: %0d unstable cycles, last valid=%b rdata=%h req_ready=%b expected 1/deadbeef/0",
                         bad, resp_valid, resp_rdata, req_ready);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0) begin
      errors++; $display("FAIL release: got req_ready=%b valid=%b rdata=%h expected 1/0/0", req_ready, resp_valid, resp_rdata);
    end
  endtask

  task automatic test_reset_in_wait();
    int seen;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_ready: got %b expected 1", req_ready); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_wait_dropped: got %0d valid cycles expected 0", seen); end
  endtask

  task automatic test_mmio();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] v1;
    drive_txn(1'b1, 32'hFFFF_FF04, 32'h0000_00FF, 4'hF, rd, er, lat);
`ifdef DMEM_RESPONDER_MMIO_EN
    checks++;
    if (er !== 1'b0 || mmio_led !== 32'hFF) begin
      errors++; $display("FAIL led_write: got err=%b led=%h expected 0/000000ff", er, mmio_led);
    end
    drive_txn(1'b0, 32'hFFFF_FF00, 32'h0, 4'h0, rd, er, lat);
    v1 = rd;
    repeat (7) @(negedge clk);
    drive_txn(1'b0, 32'hFFFF_FF00, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd - v1 !== 32'd10 || er !== 1'b0) begin
      errors++; $display("FAIL cycle_delta: got %0d err=%b expected 10/0", rd - v1, er);
    end
    drive_txn(1'b1, 32'hFFFF_FF00, 32'h1, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL cnt_write_err: got %b expected 1", er); end
`else
    checks++;
    if (er !== 1'b1 || mmio_led !== 32'd0) begin
      errors++; $display("FAIL led_disabled: got err=%b led=%h expected 1/0", er, mmio_led);
    end
    drive_txn(1'b0, 32'hFFFF_FF00, 32'h0, 4'h0, rd, er, lat);
    v1 = rd;
    checks++;
    if (er !== 1'b1 || v1 !== 32'd0) begin
      errors++; $display("FAIL cnt_disabled: got err=%b rdata=%h expected 1/0", er, v1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_reset_in_wait();
    test_mmio();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
